// File: rtl/iq_issuer_pkg.sv
// Shared encodings and sizing for the instruction-queue issuer.
// DRAIN_CYCLES is derived from the slowest (arithmetic) pipeline so the queue reset never cuts off work in flight.
package iq_issuer_pkg;

  localparam int SUPERSCALAR_WIDTH     = 16;
  localparam int LOG_SUPERSCALAR_WIDTH = 4;
  localparam int ADDR_W                = 18;
  localparam int COUNT_W               = 16;

  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;

  localparam int RAM_LATENCY   = 4;
  localparam int LD_ST_LATENCY = 6;
  localparam int ARITH_LATENCY = 9;
  localparam int DRAIN_CYCLES  = ARITH_LATENCY + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_RESET_IQ
  } issuer_state_t;

endpackage

// File: rtl/iq_issuer_drain_timer.sv
// Counts consecutive cycles with the queue empty while draining; done once DRAIN_CYCLES have elapsed.
// Down-counter reloaded whenever the queue is non-empty or the drain is not active.
module iq_drain_timer #(
  parameter int DRAIN_CYCLES = iq_issuer_pkg::DRAIN_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic empty,
  output logic done
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !active || !empty)
      cnt <= CW'(DRAIN_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign done = active && (cnt == '0);

endmodule

// File: rtl/iq_issuer.sv
// Instruction-queue issuer: splits loop instructions into pushes of up to SUPERSCALAR_WIDTH copies
// and sequences queue resets. Define IQ_ISSUER_STATS_EN to add push / stall statistics outputs.
//
// state    | meaning
// IDLE     | waiting for an instruction (in_ready unless the queue needs a reset)
// ISSUE    | pushing chunks of the latched instruction
// DRAIN    | issue stalled, waiting for queue empty plus pipeline drain time
// RESET_IQ | one-cycle queue reset pulse, then resume or go idle
module iq_issuer
  import iq_issuer_pkg::*;
#(
  parameter int SUPERSCALAR_WIDTH     = iq_issuer_pkg::SUPERSCALAR_WIDTH,
  parameter int LOG_SUPERSCALAR_WIDTH = iq_issuer_pkg::LOG_SUPERSCALAR_WIDTH,
  parameter int DRAIN_CYCLES          = iq_issuer_pkg::DRAIN_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_instr_type,
  input  logic [15:0]                    in_count,
  input  logic [17:0]                    in_cache_addr,
  input  logic [17:0]                    in_main_mem_addr,
  input  logic [17:0]                    in_d_cache_addr,
  input  logic [17:0]                    in_d_main_mem_addr,
  input  logic [9:0]                     in_arith_instr,
  input  logic [8:0]                     in_ram_instr,
  input  logic [9:0]                     in_ld_st_instr,
  output logic                           iq_we,
  output logic [1:0]                     iq_instr_type,
  output logic [LOG_SUPERSCALAR_WIDTH:0] iq_copy_count,
  output logic [17:0]                    iq_cache_addr,
  output logic [17:0]                    iq_main_mem_addr,
  output logic [17:0]                    iq_d_cache_addr,
  output logic [17:0]                    iq_d_main_mem_addr,
  output logic [9:0]                     iq_arith_instr,
  output logic [8:0]                     iq_ram_instr,
  output logic [9:0]                     iq_ld_st_instr,
  input  logic                           iq_needs_reset,
  input  logic                           iq_empty,
  output logic                           iq_reset
`ifdef IQ_ISSUER_STATS_EN
  ,
  output logic [31:0]                    stat_pushes,
  output logic [31:0]                    stat_stall_cycles
`endif
);

  localparam logic [15:0] SSW_COUNT = 16'(SUPERSCALAR_WIDTH);
  localparam logic [LOG_SUPERSCALAR_WIDTH:0] SSW_CHUNK = (LOG_SUPERSCALAR_WIDTH + 1)'(SUPERSCALAR_WIDTH);

  issuer_state_t state;

  logic [15:0] remaining;
  logic [1:0]  instr_type;
  logic [17:0] cache_base, main_base, cache_stride, main_stride;
  logic [9:0]  arith_instr, ld_st_instr;
  logic [8:0]  ram_instr;

  logic [LOG_SUPERSCALAR_WIDTH:0] copy_now;
  logic [15:0]                    remaining_next;
  logic                           drain_done;

  assign copy_now       = (remaining >= SSW_COUNT) ? SSW_CHUNK : remaining[LOG_SUPERSCALAR_WIDTH:0];
  assign remaining_next = remaining - 16'(copy_now);
  assign in_ready       = !reset && (state == ST_IDLE) && !iq_needs_reset;

  iq_drain_timer #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_drain_timer (
    .clk   (clk),
    .reset (reset),
    .active(state == ST_DRAIN),
    .empty (iq_empty),
    .done  (drain_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      remaining          <= '0;
      instr_type         <= '0;
      cache_base         <= '0;
      main_base          <= '0;
      cache_stride       <= '0;
      main_stride        <= '0;
      arith_instr        <= '0;
      ram_instr          <= '0;
      ld_st_instr        <= '0;
      iq_we              <= 1'b0;
      iq_reset           <= 1'b0;
      iq_instr_type      <= '0;
      iq_copy_count      <= '0;
      iq_cache_addr      <= '0;
      iq_main_mem_addr   <= '0;
      iq_d_cache_addr    <= '0;
      iq_d_main_mem_addr <= '0;
      iq_arith_instr     <= '0;
      iq_ram_instr       <= '0;
      iq_ld_st_instr     <= '0;
    end else begin
      iq_we    <= 1'b0;
      iq_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iq_needs_reset) begin
            state <= ST_DRAIN;
          end else if (in_valid) begin
            remaining    <= in_count;
            instr_type   <= in_instr_type;
            cache_base   <= in_cache_addr;
            main_base    <= in_main_mem_addr;
            cache_stride <= in_d_cache_addr;
            main_stride  <= in_d_main_mem_addr;
            arith_instr  <= in_arith_instr;
            ram_instr    <= in_ram_instr;
            ld_st_instr  <= in_ld_st_instr;
            if (in_count != '0)
              state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (iq_needs_reset) begin
            state <= ST_DRAIN;
          end else begin
            iq_we              <= 1'b1;
            iq_instr_type      <= instr_type;
            iq_copy_count      <= copy_now;
            iq_cache_addr      <= cache_base;
            iq_main_mem_addr   <= main_base;
            iq_d_cache_addr    <= cache_stride;
            iq_d_main_mem_addr <= main_stride;
            iq_arith_instr     <= arith_instr;
            iq_ram_instr       <= ram_instr;
            iq_ld_st_instr     <= ld_st_instr;
            // each push covers a full superscalar group, so bases step by stride * width
            cache_base         <= cache_base + (cache_stride << LOG_SUPERSCALAR_WIDTH);
            main_base          <= main_base + (main_stride << LOG_SUPERSCALAR_WIDTH);
            remaining          <= remaining_next;
            if (remaining_next == '0)
              state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state    <= ST_RESET_IQ;
            iq_reset <= 1'b1;
          end
        end
        ST_RESET_IQ: begin
          state <= (remaining != '0) ? ST_ISSUE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IQ_ISSUER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pushes       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (iq_we && (stat_pushes != '1))
        stat_pushes <= stat_pushes + 32'd1;
      if ((state == ST_DRAIN || state == ST_RESET_IQ) && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iq_issuer.sv
// Scoreboard bench for iq_issuer: stimulus queues expected pushes, a negedge monitor pops and compares.
module tb_iq_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_instr_type;
  logic [15:0] in_count;
  logic [17:0] in_cache_addr, in_main_mem_addr, in_d_cache_addr, in_d_main_mem_addr;
  logic [9:0]  in_arith_instr, in_ld_st_instr;
  logic [8:0]  in_ram_instr;
  logic        iq_we;
  logic [1:0]  iq_instr_type;
  logic [4:0]  iq_copy_count;
  logic [17:0] iq_cache_addr, iq_main_mem_addr, iq_d_cache_addr, iq_d_main_mem_addr;
  logic [9:0]  iq_arith_instr, iq_ld_st_instr;
  logic [8:0]  iq_ram_instr;
  logic        iq_needs_reset;
  logic        iq_empty;
  logic        iq_reset;
`ifdef IQ_ISSUER_STATS_EN
  logic [31:0] stat_pushes, stat_stall_cycles;
`endif

  typedef struct packed {
    logic [1:0]  t;
    logic [4:0]  cc;
    logic [17:0] ca, ma, dca, dma;
    logic [9:0]  ar;
    logic [8:0]  rm;
    logic [9:0]  ls;
  } push_t;

  push_t sb[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  iq_issuer dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr_type     (in_instr_type),
    .in_count          (in_count),
    .in_cache_addr     (in_cache_addr),
    .in_main_mem_addr  (in_main_mem_addr),
    .in_d_cache_addr   (in_d_cache_addr),
    .in_d_main_mem_addr(in_d_main_mem_addr),
    .in_arith_instr    (in_arith_instr),
    .in_ram_instr      (in_ram_instr),
    .in_ld_st_instr    (in_ld_st_instr),
    .iq_we             (iq_we),
    .iq_instr_type     (iq_instr_type),
    .iq_copy_count     (iq_copy_count),
    .iq_cache_addr     (iq_cache_addr),
    .iq_main_mem_addr  (iq_main_mem_addr),
    .iq_d_cache_addr   (iq_d_cache_addr),
    .iq_d_main_mem_addr(iq_d_main_mem_addr),
    .iq_arith_instr    (iq_arith_instr),
    .iq_ram_instr      (iq_ram_instr),
    .iq_ld_st_instr    (iq_ld_st_instr),
    .iq_needs_reset    (iq_needs_reset),
    .iq_empty          (iq_empty),
    .iq_reset          (iq_reset)
`ifdef IQ_ISSUER_STATS_EN
    ,
    .stat_pushes       (stat_pushes),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every push must match the head of the scoreboard
  always @(negedge clk) begin
    push_t a;
    push_t e;
    if (iq_we === 1'b1) begin
      a = '{iq_instr_type, iq_copy_count, iq_cache_addr, iq_main_mem_addr, iq_d_cache_addr,
            iq_d_main_mem_addr, iq_arith_instr, iq_ram_instr, iq_ld_st_instr};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_push: got %h expected no push", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL push_data: got %h expected %h", a, e);
        end
      end
    end
  end

  task automatic set_instr(input logic [1:0] t, input logic [15:0] cnt,
                           input logic [17:0] ca, input logic [17:0] ma,
                           input logic [17:0] dca, input logic [17:0] dma,
                           input logic [9:0] ar, input logic [8:0] rm, input logic [9:0] ls);
    in_instr_type = t; in_count = cnt;
    in_cache_addr = ca; in_main_mem_addr = ma;
    in_d_cache_addr = dca; in_d_main_mem_addr = dma;
    in_arith_instr = ar; in_ram_instr = rm; in_ld_st_instr = ls;
  endtask

  // expected chunking of the currently driven instruction, up to max_chunks pushes
  task automatic expect_pushes(input int max_chunks);
    push_t       e;
    int          rem;
    logic [17:0] ca, ma;
    rem = int'(in_count);
    ca  = in_cache_addr;
    ma  = in_main_mem_addr;
    for (int i = 0; i < max_chunks && rem > 0; i++) begin
      e.t   = in_instr_type;
      e.cc  = (rem > 16) ? 5'd16 : 5'(rem);
      e.ca  = ca;
      e.ma  = ma;
      e.dca = in_d_cache_addr;
      e.dma = in_d_main_mem_addr;
      e.ar  = in_arith_instr;
      e.rm  = in_ram_instr;
      e.ls  = in_ld_st_instr;
      sb.push_back(e);
      rem -= int'(e.cc);
      ca  = ca + {in_d_cache_addr[13:0], 4'b0};
      ma  = ma + {in_d_main_mem_addr[13:0], 4'b0};
    end
  endtask

  // called at a negedge; returns at the first negedge after the accepting edge
  task automatic accept();
    int n;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; iq_needs_reset = 1'b0; iq_empty = 1'b0;
    set_instr(2'd0, 16'd0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(iq_we), 32'd0);
    chk("rst_iq_reset", 32'(iq_reset), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_copy_count", 32'(iq_copy_count), 32'd0);
    chk("rst_main_addr", 32'(iq_main_mem_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // arithmetic count 40: 16/16/8 at 0x100/0x110/0x120
    set_instr(2'd2, 16'd40, 18'h00100, 18'h00200, 18'h1, 18'h2, 10'h3A5, 9'h011, 10'h022);
    expect_pushes(99);
    accept();
    wait_ready(n);
    chk("ready_lat_40", 32'(n), 32'd4);

    // count 0: accepted, no push, ready next cycle
    set_instr(2'd1, 16'd0, 18'h00ABC, 18'h00DEF, 18'h1, 18'h1, 10'h1, 9'h1, 10'h1);
    accept();
    wait_ready(n);
    chk("ready_lat_0", 32'(n), 32'd1);

    // RAM count 16 near top of address space
    set_instr(2'd0, 16'd16, 18'h00040, 18'h3FFF0, 18'h0, 18'h2, 10'h0, 9'h1F3, 10'h0);
    expect_pushes(99);
    accept();
    wait_ready(n);
    chk("ready_lat_16", 32'(n), 32'd2);

    // same base, count 32: second chunk wraps 0x3FFF0+0x20 -> 0x00010
    set_instr(2'd0, 16'd32, 18'h00040, 18'h3FFF0, 18'h0, 18'h2, 10'h0, 9'h0C3, 10'h0);
    expect_pushes(99);
    accept();
    wait_ready(n);
    chk("ready_lat_32", 32'(n), 32'd3);

    // load/store count 17: one full chunk plus a single copy, large stride wraps
    set_instr(2'd1, 16'd17, 18'h00005, 18'h20000, 18'h3, 18'h1FFFF, 10'h155, 9'h0AA, 10'h2AA);
    expect_pushes(99);
    accept();
    wait_ready(n);
    chk("ready_lat_17", 32'(n), 32'd3);

    // needs_reset before the second of three chunks
    set_instr(2'd2, 16'd40, 18'h01000, 18'h02000, 18'h4, 18'h8, 10'h2F0, 9'h100, 10'h3FF);
    expect_pushes(99);
    accept();
    @(negedge clk);
    iq_needs_reset = 1'b1;
    @(negedge clk);
    chk("drain_no_push", 32'(iq_we), 32'd0);
    chk("drain_ready_low", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    iq_empty = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iq_reset && n < 40);
    chk("iq_reset_lat", 32'(n), 32'd11);
    iq_needs_reset = 1'b0;
    iq_empty = 1'b0;
    @(negedge clk);
    chk("iq_reset_pulse", 32'(iq_reset), 32'd0);
    @(negedge clk);
    chk("resume_push", 32'(iq_we), 32'd1);
    wait_ready(n);
    chk("resume_ready", 32'(in_ready), 32'd1);

    // needs_reset from idle, iq_empty drops mid-drain: counter restarts
    iq_needs_reset = 1'b1;
    #1;
    chk("idle_nr_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    iq_empty = 1'b1;
    repeat (4) @(negedge clk);
    iq_empty = 1'b0;
    @(negedge clk);
    iq_empty = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iq_reset && n < 40);
    chk("restart_reset_lat", 32'(n), 32'd11);
    iq_needs_reset = 1'b0;
    iq_empty = 1'b0;
    @(negedge clk);
    chk("restart_pulse", 32'(iq_reset), 32'd0);
    chk("restart_idle_ready", 32'(in_ready), 32'd1);

    // reset during count 64: only the first two chunks may appear
    set_instr(2'd2, 16'd64, 18'h00300, 18'h00400, 18'h1, 18'h1, 10'h0F0, 9'h0F0, 10'h0F0);
    expect_pushes(2);
    accept();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_we", 32'(iq_we), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_copy_count", 32'(iq_copy_count), 32'd0);
    chk("midrst_cache_addr", 32'(iq_cache_addr), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle_ready", 32'(in_ready), 32'd1);

    // clean instruction after the discarded one
    set_instr(2'd1, 16'd1, 18'h3FFFF, 18'h00001, 18'h7, 18'h9, 10'h001, 9'h002, 10'h003);
    expect_pushes(99);
    accept();
    wait_ready(n);
    chk("ready_lat_1", 32'(n), 32'd2);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iq_issuer.md
# iq_issuer

Producer-side front end of the instruction queue. Accepts one compact loop instruction per handshake (type, repeat count, base addresses and strides, opcode fields), splits it into pushes of at most SUPERSCALAR_WIDTH copies, advances base addresses per push, and drives the queue's push port. Watches the queue's needs_reset flag: stalls issue, waits for the queue to empty and the longest pipeline to drain, pulses the queue reset, then resumes the interrupted instruction.

## Interface
- SUPERSCALAR_WIDTH, 16, max copies per push (power of two)
- LOG_SUPERSCALAR_WIDTH, 4, log2 of SUPERSCALAR_WIDTH
- DRAIN_CYCLES, 10, cycles waited after queue empty before reset (>= longest pipeline latency)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid / in_ready  in / out  1  instruction handshake
- in_instr_type  in  2  INSTR_TYPE_RAM / LOAD_STORE / ARITHMETIC
- in_count  in  16  total copies; 0 = no-op
- in_cache_addr, in_main_mem_addr, in_d_cache_addr, in_d_main_mem_addr  in  18 each  bases and per-copy strides
- in_arith_instr  in  10; in_ram_instr  in  9; in_ld_st_instr  in  10  opcode fields
- iq_we  out  1  push strobe
- iq_instr_type  out  2; iq_copy_count  out  LOG_SUPERSCALAR_WIDTH+1
- iq_cache_addr, iq_main_mem_addr, iq_d_cache_addr, iq_d_main_mem_addr  out  18 each
- iq_arith_instr  out  10; iq_ram_instr  out  9; iq_ld_st_instr  out  10
- iq_needs_reset  in  1; iq_empty  in  1  queue status
- iq_reset  out  1  one-cycle queue reset pulse

## Operation
- States: IDLE, ISSUE, DRAIN, RESET_IQ.
- IDLE: in_ready = !iq_needs_reset. On in_valid&&in_ready: latch all fields, remaining <= in_count. in_count==0 → stay IDLE, no push. Otherwise → ISSUE.
- ISSUE: when !iq_needs_reset, push: iq_copy_count = min(remaining, SUPERSCALAR_WIDTH), addresses = current bases; then remaining -= copy_count, bases += stride << LOG_SUPERSCALAR_WIDTH (mod 2^18). remaining reaching 0 → IDLE.
- iq_needs_reset high in ISSUE or IDLE → DRAIN (no push that cycle, in_ready low).
- DRAIN: counter cleared while !iq_empty; counts while iq_empty; at DRAIN_CYCLES → RESET_IQ.
- RESET_IQ: iq_reset=1 one cycle; → ISSUE if remaining != 0, else IDLE.
- Opcode fields and strides pass unchanged from latch to every push.
- Reset: state IDLE, remaining 0, all latched fields 0; outputs iq_we=0, iq_reset=0, in_ready=0 in the reset cycle, all iq_* data 0. Reset mid-instruction discards the instruction.

## Timing
- All iq_* outputs registered. Accept at cycle T → first iq_we at T+1.
- Instruction of count N with no reset: ceil(N/16) consecutive iq_we cycles, then one IDLE cycle before next accept (in_ready high at T+ceil(N/16)+1).
- iq_needs_reset sampled same cycle as push decision; push suppressed that cycle.
- Reset sequence: iq_reset asserted exactly DRAIN_CYCLES+1 cycles after first iq_empty-high cycle in DRAIN; if iq_empty drops, counter restarts. Issue resumes the cycle after iq_reset.
- Count 0: accept consumes one cycle, no push.

## Configuration
- IQ_ISSUER_STATS_EN defined: adds outputs stat_pushes (32) counting iq_we cycles and stat_stall_cycles (32) counting cycles in DRAIN/RESET_IQ; both reset to 0, saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: INSTR_TYPE_* encodings, SUPERSCALAR_WIDTH, LOG_SUPERSCALAR_WIDTH, pipeline latency constants (DRAIN_CYCLES default derived from ARITH latency).
- One sub-module: iq_drain_timer (clear/count on empty, done at DRAIN_CYCLES).

## Test plan
- ARITHMETIC, count 40, cache base 0x100, stride 1 → three pushes: copy_count 16/16/8, cache_addr 0x100/0x110/0x120; in_ready back 4 cycles after accept.
- count 0 → accepted, no iq_we, in_ready high next cycle.
- RAM, count 16, main base 0x3FFF0, stride 2 → one push, copy_count 16; following instruction with same base shows 18-bit wrap on second chunk (0x3FFF0+0x20 → 0x00010).
- iq_needs_reset rises before second of three chunks, iq_empty high 3 cycles later → iq_we low, iq_reset pulse 3+DRAIN_CYCLES+1 cycles later, remaining two chunks issue with correct addresses.
- iq_empty toggles low mid-DRAIN → counter restarts, iq_reset delayed accordingly.
- reset asserted during ISSUE of count 64 → next cycle iq_we=0, state IDLE, no further pushes of that instruction.
